// File: rtl/top_module_looper.sv
// top_module_looper: tiny 16-bit core looping over a shared dual-port 64-bit memory
module top_module_looper #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_cache,
  input  logic [15:0] extern_pc,
  input  logic        extern_pc_en,
  input  logic        mmu_mem_clk,
  input  logic        mmu_mem_rst,
  input  logic        mmu_mem_enb,
  input  logic        mmu_mem_web,
  input  logic [13:0] mmu_mem_addrb,
  input  logic [63:0] mmu_mem_dinb,
  output logic [63:0] mmu_mem_doutb
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM} state_t;
  state_t      r_state, w_state_next, w_done_next;
  logic [15:0] r_pc, w_pc_next;
  logic [15:0] r_regs [16];
  logic [63:0] r_mem [MEM_DEPTH];
  logic [63:0] r_douta;
  logic [3:0]  r_ld_rd;
  logic [1:0]  r_ld_lane;
  logic [15:0] w_instr, w_rd_val, w_rs_val, w_rt_val, w_reg_wd;
  logic [3:0]  w_op, w_rd, w_rs, w_rt, w_reg_wa;
  logic [7:0]  w_imm;
  logic [13:0] w_addr_a;
  logic        w_reg_we, w_st_we, w_rd_a_en, w_b_wr, w_unused_clk;
  assign w_unused_clk = mmu_mem_clk;
  assign w_instr  = r_douta[{~r_pc[1:0], 4'b0} +: 16];
  assign w_op     = w_instr[15:12];
  assign w_rd     = w_instr[11:8];
  assign w_rs     = w_instr[7:4];
  assign w_rt     = w_instr[3:0];
  assign w_imm    = w_instr[7:0];
  assign w_rd_val = (w_rd == 4'd0) ? 16'd0 : r_regs[w_rd];
  assign w_rs_val = (w_rs == 4'd0) ? 16'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 4'd0) ? 16'd0 : r_regs[w_rt];
  assign w_addr_a = (r_state == S_EXEC) ? w_rs_val[15:2] : r_pc[15:2];
  assign w_b_wr   = mmu_mem_enb && mmu_mem_web;
  assign w_done_next = flush_cache ? S_IDLE : S_FETCH;
  // next state, PC and write strobes; a restart pulse suppresses every write
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_reg_we     = 1'b0;
    w_reg_wa     = w_rd;
    w_reg_wd     = 16'd0;
    w_st_we      = 1'b0;
    w_rd_a_en    = 1'b0;
    if (extern_pc_en) begin
      w_state_next = S_FETCH;
      w_pc_next    = extern_pc;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_rd_a_en    = 1'b1;
          w_state_next = S_EXEC;
        end
        S_EXEC: begin
          w_pc_next    = r_pc + 16'd1;
          w_state_next = w_done_next;
          case (w_op)
            4'd1: begin w_reg_we = 1'b1; w_reg_wd = {8'd0, w_imm}; end
            4'd2: begin w_reg_we = 1'b1; w_reg_wd = w_rs_val + w_rt_val; end
            4'd3: begin w_reg_we = 1'b1; w_reg_wd = w_rs_val - w_rt_val; end
            4'd4: begin w_rd_a_en = 1'b1; w_state_next = S_MEM; end
            4'd5: w_st_we = 1'b1;
            4'd6: w_pc_next = (w_rd_val != 16'd0) ? r_pc + 16'd1 + {{8{w_imm[7]}}, w_imm} : r_pc + 16'd1;
            4'd7: w_state_next = S_IDLE;
            default: ;
          endcase
        end
        S_MEM: begin
          w_reg_we     = 1'b1;
          w_reg_wa     = r_ld_rd;
          w_reg_wd     = r_douta[{~r_ld_lane, 4'b0} +: 16];
          w_state_next = w_done_next;
        end
        default: ;
      endcase
    end
  end
  // core state, PC and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= 16'd0;
      for (int i = 0; i < 16; i++) r_regs[i] <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_reg_we && w_reg_wa != 4'd0) r_regs[w_reg_wa] <= w_reg_wd;
    end
  end
  // LD destination and lane, held for the MEM cycle once r_douta is reused
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC) begin
      r_ld_rd   <= w_rd;
      r_ld_lane <= w_rs_val[1:0];
    end
  end
  // shared memory: port A lane store and read, port B full-word write wins on collision
  always_ff @(posedge clk) begin
    if (w_rd_a_en) r_douta <= r_mem[w_addr_a];
    if (w_st_we && !(w_b_wr && mmu_mem_addrb == w_addr_a))
      r_mem[w_addr_a][{~w_rs_val[1:0], 4'b0} +: 16] <= w_rd_val;
    if (w_b_wr) r_mem[mmu_mem_addrb] <= mmu_mem_dinb;
  end
  // port B read-first output register, cleared by either reset, held when disabled
  always_ff @(posedge clk) begin
    if (rst || mmu_mem_rst) mmu_mem_doutb <= 64'd0;
    else if (mmu_mem_enb) mmu_mem_doutb <= r_mem[mmu_mem_addrb];
  end
endmodule

// File: tb/tb_top_module_looper.sv
// tb_top_module_looper: directed checks of port B and small core programs
module tb_top_module_looper;
  logic        clk = 1'b0;
  logic        rst, flush_cache, extern_pc_en, mmu_mem_clk, mmu_mem_rst;
  logic        mmu_mem_enb, mmu_mem_web;
  logic [15:0] extern_pc;
  logic [13:0] mmu_mem_addrb;
  logic [63:0] mmu_mem_dinb, mmu_mem_doutb, d;
  int          n_checks = 0, n_errors = 0;

  top_module_looper dut (
    .clk(clk), .rst(rst), .flush_cache(flush_cache), .extern_pc(extern_pc),
    .extern_pc_en(extern_pc_en), .mmu_mem_clk(mmu_mem_clk), .mmu_mem_rst(mmu_mem_rst),
    .mmu_mem_enb(mmu_mem_enb), .mmu_mem_web(mmu_mem_web), .mmu_mem_addrb(mmu_mem_addrb),
    .mmu_mem_dinb(mmu_mem_dinb), .mmu_mem_doutb(mmu_mem_doutb)
  );

  always #5 clk = ~clk;
  assign mmu_mem_clk = clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pb_write(input logic [13:0] a, input logic [63:0] v);
    mmu_mem_enb = 1'b1; mmu_mem_web = 1'b1; mmu_mem_addrb = a; mmu_mem_dinb = v;
    @(negedge clk);
    mmu_mem_enb = 1'b0; mmu_mem_web = 1'b0;
  endtask

  task automatic pb_read(input logic [13:0] a, output logic [63:0] v);
    mmu_mem_enb = 1'b1; mmu_mem_web = 1'b0; mmu_mem_addrb = a;
    @(negedge clk);
    mmu_mem_enb = 1'b0;
    v = mmu_mem_doutb;
  endtask

  task automatic pulse_pc(input logic [15:0] a);
    extern_pc_en = 1'b1; extern_pc = a;
    @(negedge clk);
    extern_pc_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush_cache = 1'b0; extern_pc = 16'd0; extern_pc_en = 1'b0;
    mmu_mem_rst = 1'b0; mmu_mem_enb = 1'b0; mmu_mem_web = 1'b0;
    mmu_mem_addrb = 14'd0; mmu_mem_dinb = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_doutb", mmu_mem_doutb, 64'd0);
    check("rst_state", 64'(dut.r_state), 64'd0);
    extern_pc_en = 1'b1; extern_pc = 16'h0040;
    @(negedge clk);
    check("rst_over_pc_en", 64'(dut.r_state), 64'd0);
    rst = 1'b0; extern_pc_en = 1'b0;
    // port B basics
    pb_write(14'd0, 64'd0);
    pb_read(14'd0, d);
    check("pb_addr0", d, 64'd0);
    pb_write(14'h3FFF, 64'hA5A5_5A5A_0123_4567);
    pb_read(14'h3FFF, d);
    check("pb_top", d, 64'hA5A5_5A5A_0123_4567);
    @(negedge clk);
    check("pb_hold", mmu_mem_doutb, 64'hA5A5_5A5A_0123_4567);
    pb_write(14'h3FFF, 64'h0000_0000_0000_0123);
    check("pb_read_first", mmu_mem_doutb, 64'hA5A5_5A5A_0123_4567);
    pb_read(14'h3FFF, d);
    check("pb_new", d, 64'h0000_0000_0000_0123);
    // LDI/ADD/ST then HALT from halfword 4
    pb_write(14'd1, 64'h1105_1203_2312_1420);
    pb_write(14'd2, 64'h5340_7000_0000_0000);
    pb_write(14'd8, 64'h1111_AAAA_BBBB_CCCC);
    pulse_pc(16'h0004);
    repeat (20) @(negedge clk);
    pb_read(14'd8, d);
    check("add_store", d, 64'h0008_AAAA_BBBB_CCCC);
    // countdown loop from halfword 16, with mmu_mem_rst mid-run
    pb_write(14'd0, 64'hDEAD_BEEF_CAFE_F00D);
    pb_write(14'd4, 64'h1103_1201_3112_61FE);
    pb_write(14'd5, 64'h5100_7000_0000_0000);
    pb_read(14'd8, d);
    pulse_pc(16'h0010);
    repeat (4) @(negedge clk);
    mmu_mem_rst = 1'b1;
    @(negedge clk);
    mmu_mem_rst = 1'b0;
    check("mmu_rst_doutb", mmu_mem_doutb, 64'd0);
    repeat (14) @(negedge clk);
    check("loop_running", 64'(dut.r_state), 64'd2);
    @(negedge clk);
    check("loop_idle", 64'(dut.r_state), 64'd0);
    pb_read(14'd0, d);
    check("loop_result", d, 64'h0000_BEEF_CAFE_F00D);
    // flush mid-program: the store never happens
    pb_write(14'd0, 64'h1234_5678_9ABC_DEF0);
    pulse_pc(16'h0010);
    repeat (3) @(negedge clk);
    flush_cache = 1'b1;
    repeat (30) @(negedge clk);
    check("flush_idle", 64'(dut.r_state), 64'd0);
    pb_read(14'd0, d);
    check("flush_mem", d, 64'h1234_5678_9ABC_DEF0);
    flush_cache = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_stay_idle", 64'(dut.r_state), 64'd0);
    pb_read(14'd0, d);
    check("flush_mem_stable", d, 64'h1234_5678_9ABC_DEF0);
    // restart to a HALT while ST is in EXEC aborts the store
    pb_write(14'd10, 64'h1155_1230_5120_0000);
    pb_write(14'd11, 64'h7000_0000_0000_0000);
    pb_write(14'd12, 64'h0BAD_0000_0000_0001);
    pulse_pc(16'd40);
    repeat (5) @(negedge clk);
    pulse_pc(16'd44);
    repeat (6) @(negedge clk);
    check("abort_idle", 64'(dut.r_state), 64'd0);
    pb_read(14'd12, d);
    check("abort_no_store", d, 64'h0BAD_0000_0000_0001);
    pulse_pc(16'd40);
    repeat (20) @(negedge clk);
    pb_read(14'd12, d);
    check("store_lane0", d, 64'h0055_0000_0000_0001);
    // ST then LD of the same halfword, then store the loaded value
    pb_write(14'd14, 64'h1177_1240_5120_4320);
    pb_write(14'd15, 64'h1444_5340_7000_0000);
    pb_write(14'd16, 64'hFFFF_0000_0000_0000);
    pb_write(14'd17, 64'h0000_1111_2222_3333);
    pulse_pc(16'd56);
    repeat (30) @(negedge clk);
    pb_read(14'd16, d);
    check("st_word", d, 64'h0077_0000_0000_0000);
    pb_read(14'd17, d);
    check("ld_after_st", d, 64'h0077_1111_2222_3333);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/top_module_looper.md
TOP_MODULE_LOOPER -- requirements
Module: top_module_looper

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16384, meaning the number of 64-bit words in unified memory (address width 14).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush_cache  input  1  quiesce request; core stops at the next instruction boundary while high.
REQ-005 extern_pc  input  16  start PC, in halfword units.
REQ-006 extern_pc_en  input  1  one-cycle pulse loading extern_pc and starting execution.
REQ-007 mmu_mem_clk  input  1  unused; port B is clocked by clk.
REQ-008 mmu_mem_rst  input  1  synchronous active-high clear of the mmu_mem_doutb register only.
REQ-009 mmu_mem_enb  input  1  port B enable.
REQ-010 mmu_mem_web  input  1  port B write enable; qualified by mmu_mem_enb.
REQ-011 mmu_mem_addrb  input  14  port B word address.
REQ-012 mmu_mem_dinb  input  64  port B write data.
REQ-013 mmu_mem_doutb  output  64  port B registered read data.

Function
REQ-014 Memory SHALL be MEM_DEPTH x 64 bits and true dual-port: port A is internal to the core, port B is external.
REQ-015 Halfword address H SHALL map to word H[15:2] and lane H[1:0]; lane 0 = bits 63:48, lane 3 = bits 15:0.
REQ-016 Port B SHALL have read latency 1 and be read-first: doutb returns the old data on a write.
REQ-017 doutb SHALL hold its value when enb=0.
REQ-018 When port A and port B write the same word in the same cycle, port B SHALL win.
REQ-019 The core SHALL have 16 registers of 16 bits; r0 reads 0 and writes to r0 are discarded.
REQ-020 Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8 = [7:0].
REQ-021 Opcode semantics:
- 0 NOP.
- 1 LDI: rd = zero-extended imm8.
- 2 ADD: rd = rs + rt, mod 2^16.
- 3 SUB: rd = rs - rt, mod 2^16.
- 4 LD: rd = mem16[rs].
- 5 ST: mem16[rs] = rd.
- 6 BNZ: if rd != 0, PC = PC + 1 + sign-extended imm8.
- 7 HALT.
- 8-15 execute as NOP.
REQ-022 Non-branch instructions and untaken BNZ SHALL advance PC by 1, wrapping 0xFFFF to 0x0000.
REQ-023 State machine states: IDLE, FETCH, EXEC, MEM.
- IDLE -> FETCH on extern_pc_en.
- FETCH issues the port A read -> EXEC.
- EXEC -> MEM for LD; MEM writes rd -> FETCH.
- HALT -> IDLE.
- All other instructions -> FETCH.
REQ-024 Instruction latency SHALL be 2 cycles; LD SHALL take 3 cycles.
REQ-025 ST SHALL perform a byte-lane read-modify-free write in EXEC: only the addressed 16-bit lane changes.
REQ-026 extern_pc_en in any state SHALL load PC and enter FETCH next cycle; an instruction in EXEC or MEM that cycle SHALL be abandoned with no register or memory write.
REQ-027 With flush_cache=1, the core SHALL enter IDLE instead of FETCH after completing the current instruction; extern_pc_en still restarts it.
REQ-028 An LD immediately after a ST to the same halfword SHALL return the stored value.

Reset
REQ-029 rst SHALL set state=IDLE, PC=0x0000, all registers to 0 and mmu_mem_doutb to 0.
REQ-030 Memory contents SHALL NOT be changed by rst or by mmu_mem_rst.
REQ-031 rst SHALL take priority over extern_pc_en.
REQ-032 Port B SHALL remain fully operational while the core is IDLE, running or in reset.

Verification
REQ-033 Write 0x0000 with port B; read address 0 -> doutb = 0 next cycle; write address 0x3FFF, read back -> same value.
REQ-034 Load word 1 = {1105,1203,2312,1420} and word 2 = {5340,7000,0000,0000} via port B; extern_pc=0x0004 pulse; after 20 cycles read word 8 -> doutb[63:48] = 0x0008, other lanes unchanged.
REQ-035 Loop program: LDI r1,3; LDI r2,1; SUB r1,r1,r2; BNZ r1,-2; ST r1,[r0]; HALT -> lane 0 of word 0 = 0x0000; the loop body executes exactly 3 times.
REQ-036 Assert flush_cache while running -> no further port A writes, and memory is stable for readback through port B.
REQ-037 Pulse extern_pc_en to a HALT address while a ST is in EXEC -> the store does not occur.
REQ-038 Assert mmu_mem_rst -> doutb = 0 next cycle, and core state is unaffected.
